// File: rtl/rotfpga_scan_loader.sv
// Scan-chain initiator: serialises config bytes onto the grid chain and
// returns the chain's previous contents as readback bytes, bit 0 first.
module rotfpga_scan_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    input  logic       rb_ready,
    output logic       scan_en,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       busy,
    output logic       done
);

    // Handshakes: a transfer happens on a clk edge where valid and ready are
    // both high; ready/valid here decode from state only, never from inputs.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] bitcnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rb_sr;
    logic [3:0]       nb;
    logic [3:0]       sidx;
    logic [31:0]      remain;
    logic [3:0]       nb_d;
    logic             last_bit;
    logic             load_done;

    // Bits still to shift in this load; the last byte may be partial.
    assign remain    = 32'(CHAIN_LEN) - 32'(bitcnt);
    assign nb_d      = (remain >= 32'd8) ? 4'd8 : remain[3:0];
    assign last_bit  = (sidx == nb - 4'd1);
    assign load_done = (bitcnt == CNT_W'(CHAIN_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        scan_en   = 1'b0;
        scan_in   = 1'b0;
        cfg_ready = 1'b0;
        rb_valid  = 1'b0;
        rb_data   = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_d = SHIFT;
            end
            SHIFT: begin
                scan_en = 1'b1;
                scan_in = tx_sr[0];
                if (last_bit) state_d = OUT;
            end
            OUT: begin
                rb_valid = 1'b1;
                rb_data  = rb_sr;
                if (rb_ready) state_d = load_done ? FIN : LOAD;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitcnt <= '0;
            tx_sr  <= 8'h00;
            rb_sr  <= 8'h00;
            nb     <= 4'd0;
            sidx   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) bitcnt <= '0;
                end
                LOAD: begin
                    if (cfg_valid) begin
                        tx_sr <= cfg_data;
                        rb_sr <= 8'h00;
                        nb    <= nb_d;
                        sidx  <= 4'd0;
                    end
                end
                SHIFT: begin
                    // scan_out still holds the pre-shift last flop on this edge.
                    tx_sr            <= {1'b0, tx_sr[7:1]};
                    rb_sr[sidx[2:0]] <= scan_out;
                    bitcnt           <= bitcnt + CNT_W'(1);
                    sidx             <= sidx + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rotfpga_scan_loader.sv
// Bench for rotfpga_scan_loader: two instances (16- and 12-bit chains) behind
// behavioural scan chains, driven by randomized loads and checked by a model.
module tb_rotfpga_scan_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       rb_ready;
    logic       sel;

    logic       cfg_ready_a, rb_valid_a, scan_en_a, scan_in_a, busy_a, done_a;
    logic [7:0] rb_data_a;
    logic       cfg_ready_b, rb_valid_b, scan_en_b, scan_in_b, busy_b, done_b;
    logic [7:0] rb_data_b;

    logic [15:0] ch_a;
    logic [11:0] ch_b;
    logic        pre_en;
    logic [15:0] pre_val;

    rotfpga_scan_loader #(.CHAIN_LEN(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid & ~sel), .cfg_ready(cfg_ready_a),
        .rb_data(rb_data_a), .rb_valid(rb_valid_a), .rb_ready(rb_ready & ~sel),
        .scan_en(scan_en_a), .scan_in(scan_in_a), .scan_out(ch_a[0]),
        .busy(busy_a), .done(done_a)
    );

    rotfpga_scan_loader #(.CHAIN_LEN(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid & sel), .cfg_ready(cfg_ready_b),
        .rb_data(rb_data_b), .rb_valid(rb_valid_b), .rb_ready(rb_ready & sel),
        .scan_en(scan_en_b), .scan_in(scan_in_b), .scan_out(ch_b[0]),
        .busy(busy_b), .done(done_b)
    );

    wire       cfg_ready = sel ? cfg_ready_b : cfg_ready_a;
    wire       rb_valid  = sel ? rb_valid_b  : rb_valid_a;
    wire [7:0] rb_data   = sel ? rb_data_b   : rb_data_a;
    wire       scan_en   = sel ? scan_en_b   : scan_en_a;
    wire       scan_in   = sel ? scan_in_b   : scan_in_a;
    wire       busy      = sel ? busy_b      : busy_a;
    wire       done      = sel ? done_b      : done_a;
    wire [15:0] chain    = sel ? {4'h0, ch_b} : ch_a;

    // Grid chains: scan_in enters the first flop, scan_out is flop 0.
    always @(posedge clk) begin
        if (pre_en) begin
            ch_a <= pre_val;
            ch_b <= pre_val[11:0];
        end else begin
            if (scan_en_a) ch_a <= {scan_in_a, ch_a[15:1]};
            if (scan_en_b) ch_b <= {scan_in_b, ch_b[11:1]};
        end
    end

    int sen_cnt  = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (scan_en) sen_cnt = sen_cnt + 1;
        if (done)    done_cnt = done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic do_load(input bit fixed, input logic [15:0] fpre, input logic [7:0] f0,
                           input logic [7:0] f1, input int gmin, input int gmax,
                           input int bpmin, input int bpmax, input bit poke);
        int         len, n, mask, gap, bp, guard, sen0, done0;
        logic [15:0] pre, exp_chain, c0;
        logic [7:0]  cfg[2];
        logic [7:0]  held, exp_b;
        len = sel ? 12 : 16;
        pre = fixed ? fpre : 16'($urandom);
        if (sel) pre[15:12] = 4'h0;
        cfg[0] = fixed ? f0 : 8'($urandom);
        cfg[1] = fixed ? f1 : 8'($urandom);
        preload(pre);
        exp_chain = 16'h0;
        for (int i = 0; i < 2; i++) begin
            n    = (len - 8 * i >= 8) ? 8 : len - 8 * i;
            mask = (1 << n) - 1;
            exp_q.push_back(8'((32'(pre) >> (8 * i)) & mask));
            exp_chain = exp_chain | 16'((32'(cfg[i]) & mask) << (8 * i));
        end
        sen0  = sen_cnt;
        done0 = done_cnt;

        cfg_valid = 1'b1;
        cfg_data  = cfg[0];
        @(negedge clk);
        check("idle_cfg_ready", 32'(cfg_ready), 0);
        check("idle_scan_en", 32'(scan_en), 0);
        check("idle_busy", 32'(busy), 0);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;

        for (int i = 0; i < 2; i++) begin
            gap = $urandom_range(gmax, gmin);
            for (int k = 0; k < gap; k++) begin
                @(negedge clk);
                check("gap_cfg_ready", 32'(cfg_ready), 1);
                check("gap_scan_en", 32'(scan_en), 0);
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = cfg[i];
            guard = 0;
            @(negedge clk);
            while (!cfg_ready && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            check("cfg_ready_timeout", 32'(cfg_ready), 1);
            tick();
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            if (poke && i == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            guard = 0;
            @(negedge clk);
            while (!rb_valid && guard < 30) begin
                guard++;
                @(negedge clk);
            end
            check("rb_valid_timeout", 32'(rb_valid), 1);
            held = rb_data;
            c0   = chain;
            bp   = $urandom_range(bpmax, bpmin);
            for (int k = 0; k < bp; k++) begin
                check("bp_scan_en", 32'(scan_en), 0);
                check("bp_rb_stable", 32'(rb_data), 32'(held));
                check("bp_chain_frozen", 32'(chain), 32'(c0));
                @(negedge clk);
            end
            rb_ready = 1'b1;
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("rb_byte", 32'(rb_data), 32'(exp_b));
            if (len == 12 && i == 1) check("rb_upper_zero", 32'(rb_data[7:4]), 0);
            tick();
            rb_ready = 1'b0;
        end

        @(negedge clk);
        check("fin_done", 32'(done), 1);
        check("fin_busy", 32'(busy), 1);
        @(negedge clk);
        check("idle_done", 32'(done), 0);
        check("idle_busy_after", 32'(busy), 0);
        check("chain_result", 32'(chain), 32'(exp_chain));
        check("scan_en_cycles", 32'(sen_cnt - sen0), 32'(len));
        check("done_pulses", 32'(done_cnt - done0), 1);
        tick();
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {21'h0, cfg_ready, rb_valid, rb_data, scan_en, scan_in, busy, done}, 0);
    endtask

    initial begin
        int seen, guard;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_data  = 8'h00;
        cfg_valid = 1'b0;
        rb_ready  = 1'b0;
        sel       = 1'b0;
        pre_en    = 1'b1;
        pre_val   = 16'h0;
        repeat (3) tick();
        pre_en = 1'b0;
        @(negedge clk);
        check_quiet("reset_a");
        sel = 1'b1;
        #1;
        check_quiet("reset_b");
        sel = 1'b0;
        rst_n = 1'b1;
        tick();

        do_load(1'b1, 16'hBEEF, 8'h34, 8'h12, 0, 0, 0, 0, 1'b0);
        check("directed_16", 32'(chain), 32'h1234);
        do_load(1'b0, 16'h0, 8'h0, 8'h0, 0, 0, 5, 5, 1'b1);
        sel = 1'b1;
        do_load(1'b1, 16'h0123, 8'hAB, 8'hFD, 0, 0, 0, 0, 1'b0);
        check("directed_12", 32'(chain), 32'hDAB);
        do_load(1'b0, 16'h0, 8'h0, 8'h0, 4, 4, 0, 2, 1'b0);
        for (int r = 0; r < 10; r++) begin
            sel = 1'($urandom_range(1, 0));
            do_load(1'b0, 16'h0, 8'h0, 8'h0, 0, 4, 0, 4, 1'($urandom_range(1, 0)));
        end

        // Abort a load mid-shift, then run a clean load.
        sel = 1'b0;
        preload(16'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        tick();
        cfg_valid = 1'b0;
        seen  = 0;
        guard = 0;
        while (seen < 3 && guard < 20) begin
            @(negedge clk);
            if (scan_en) seen++;
            guard++;
        end
        check("abort_shifts_seen", 32'(seen), 3);
        tick();
        rst_n     = 1'b0;
        cfg_valid = 1'b1;
        tick();
        @(negedge clk);
        check_quiet("abort_quiet");
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        tick();
        @(negedge clk);
        check_quiet("abort_idle");
        tick();
        do_load(1'b0, 16'h0, 8'h0, 8'h0, 0, 2, 0, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
